// File: rtl/io_timer.sv
`default_nettype none
// ============================================================================
//  Module      : io_timer
//  Description : I/O-mapped programmable interval timer on the multiplexed
//                8085-style system bus. The CPU programs a 14-bit down-counter
//                and a mode through IN/OUT cycles. The block produces a timer
//                waveform and a latched terminal-count flag (also driven out
//                as the interrupt).
//  Ports       : clk, rst        - clock and synchronous active-high reset
//                address[7:0]    - low CPU address byte; [1:0] select the register
//                data[7:0]       - shared bus, driven only during a selected read
//                IOMn,RDn,WRn,CSn- bus cycle type and strobes (RDn/WRn/CSn active low)
//                tick            - count enable, one decrement per enabled clock
//                timer_out, irq  - timer waveform and TC flag
//  Revision    : 1.0 - initial release
// ============================================================================
module io_timer #(
    parameter logic [7:0] BASE_PORT = 8'h40,
    parameter int         MIN_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] address,
    inout  wire  [7:0] data,
    input  logic       IOMn,
    input  logic       RDn,
    input  logic       WRn,
    input  logic       CSn,
    input  logic       tick,
    output logic       timer_out,
    output logic       irq
);

    localparam logic [13:0] c_min_count = 14'(MIN_COUNT);

    logic [13:0] r_count_reg;   // programmed count (CPU view)
    logic [1:0]  r_mode;        // programmed mode (CPU view)
    logic [13:0] r_cnt;         // live down-counter
    logic [13:0] r_n;           // count latched for the active period
    logic [1:0]  r_amode;       // mode latched for the active period
    logic        r_running;
    logic        r_stop_pend;
    logic        r_tc_flag;
    logic        r_timer_out;
    logic        r_wr_q;
    logic        r_rd_q;

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_wr_commit;
    logic        w_cmd_commit;
    logic        w_rd_end;
    logic        w_rd_drive;
    logic [7:0]  w_rdata;
    logic [13:0] w_load;
    logic        w_tc;
    logic [13:0] w_cnt_n;
    logic [13:0] w_n_n;
    logic [1:0]  w_amode_n;
    logic        w_running_n;
    logic        w_stop_pend_n;
    logic        w_out_n;

    assign w_sel        = ~CSn & IOMn & (address[7:2] == BASE_PORT[7:2]);
    assign w_off        = address[1:0];
    // Commit only on the first clock of a write strobe (previous WRn was high).
    assign w_wr_commit  = w_sel & ~WRn & r_wr_q;
    assign w_cmd_commit = w_wr_commit & (w_off == 2'd0);
    // A status read ends when RDn returns high after having been low.
    assign w_rd_end     = w_sel & (w_off == 2'd0) & RDn & ~r_rd_q;
    // Suppress driving when both strobes are low to avoid bus contention.
    assign w_rd_drive   = w_sel & ~RDn & WRn;
    assign w_load       = (r_count_reg < c_min_count) ? c_min_count : r_count_reg;

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            2'd0:    w_rdata = {1'b0, r_tc_flag, 5'b0, r_running};
            2'd1:    w_rdata = r_count_reg[7:0];
            2'd2:    w_rdata = {r_mode, r_count_reg[13:8]};
            default: w_rdata = 8'h00;
        endcase
    end

    assign data = w_rd_drive ? w_rdata : 8'hzz;

    // Next-state for the counter; commands are applied after counting so a
    // stop-now or restart overrides whatever the count did this cycle.
    always_comb begin
        w_tc          = r_running & tick & (r_cnt == 14'd1);
        w_cnt_n       = r_cnt;
        w_n_n         = r_n;
        w_amode_n     = r_amode;
        w_running_n   = r_running;
        w_stop_pend_n = r_stop_pend;

        if (r_running && tick) begin
            if (w_tc) begin
                if (r_amode[0] && !r_stop_pend) begin
                    w_cnt_n   = w_load;
                    w_n_n     = w_load;
                    w_amode_n = r_mode;
                end else begin
                    w_running_n   = 1'b0;
                    w_stop_pend_n = 1'b0;
                end
            end else begin
                w_cnt_n = r_cnt - 14'd1;
            end
        end

        if (w_cmd_commit) begin
            case (data[7:6])
                2'b01: w_running_n = 1'b0;
                2'b10: if (r_running) w_stop_pend_n = 1'b1;
                2'b11: begin
                    w_cnt_n       = w_load;
                    w_n_n         = w_load;
                    w_amode_n     = r_mode;
                    w_running_n   = 1'b1;
                    w_stop_pend_n = 1'b0;
                end
                default: ;
            endcase
        end

        // Pulse modes go low only on the last count; square modes stay high
        // while the count is above half the latched period.
        if (!w_running_n)
            w_out_n = 1'b1;
        else if (w_amode_n[1])
            w_out_n = (w_cnt_n > (w_n_n >> 1));
        else
            w_out_n = (w_cnt_n != 14'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_reg <= 14'd0;
            r_mode      <= 2'b00;
            r_cnt       <= 14'd0;
            r_n         <= 14'd0;
            r_amode     <= 2'b00;
            r_running   <= 1'b0;
            r_stop_pend <= 1'b0;
            r_tc_flag   <= 1'b0;
            r_timer_out <= 1'b1;
            r_wr_q      <= 1'b1;
            r_rd_q      <= 1'b1;
        end else begin
            r_wr_q      <= WRn;
            r_rd_q      <= RDn;
            r_cnt       <= w_cnt_n;
            r_n         <= w_n_n;
            r_amode     <= w_amode_n;
            r_running   <= w_running_n;
            r_stop_pend <= w_stop_pend_n;
            r_timer_out <= w_out_n;
            if (w_wr_commit && (w_off == 2'd1))
                r_count_reg[7:0] <= data;
            if (w_wr_commit && (w_off == 2'd2)) begin
                r_count_reg[13:8] <= data[5:0];
                r_mode            <= data[7:6];
            end
            if (w_tc)
                r_tc_flag <= 1'b1;
            else if (w_rd_end)
                r_tc_flag <= 1'b0;
        end
    end

    assign timer_out = r_timer_out;
    assign irq       = r_tc_flag;

endmodule
`default_nettype wire

// File: tb/tb_io_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_timer
//  Description : Self-checking bench for io_timer. A reference model tracks
//                the timer as "ticks elapsed in the current period" and feeds
//                expected waveform and read data into queues; a monitor pops
//                and compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] address;
    wire  [7:0] data;
    logic       IOMn, RDn, WRn, CSn, tick;
    logic       timer_out, irq;

    logic [7:0] tb_data;
    logic       tb_drive;
    logic       rand_tick;
    logic       tick_fix;

    assign data = tb_drive ? tb_data : 8'hzz;

    io_timer #(.BASE_PORT(8'h40), .MIN_COUNT(2)) dut (
        .clk(clk), .rst(rst), .address(address), .data(data),
        .IOMn(IOMn), .RDn(RDn), .WRn(WRn), .CSn(CSn), .tick(tick),
        .timer_out(timer_out), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] wave_q[$];   // {timer_out, irq} expected each cycle
    logic [7:0] rd_q[$];     // expected read data per read strobe

    // Reference model: the period is tracked as ticks elapsed (m_k of m_n).
    int          m_k, m_n;
    bit          m_run, m_pend, m_flag;
    logic [13:0] m_creg;
    logic [1:0]  m_mreg, m_mode;
    bit          m_prev_wr, m_prev_rd;

    function automatic int load_val(input logic [13:0] c);
        return (int'(c) < 2) ? 2 : int'(c);
    endfunction

    function automatic logic [7:0] model_rd(input logic [1:0] off);
        case (off)
            2'd0:    return {1'b0, m_flag, 5'b0, m_run};
            2'd1:    return m_creg[7:0];
            2'd2:    return {m_mreg, m_creg[13:8]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_step();
        bit sel, commit, rd_end, tc, old_run;
        bit out;
        sel    = !CSn && IOMn && (address[7:2] == 6'h10);
        commit = sel && !WRn && m_prev_wr;
        rd_end = sel && (address[1:0] == 2'd0) && RDn && !m_prev_rd;
        if (rst) begin
            m_k = 0; m_n = 0; m_run = 0; m_pend = 0; m_flag = 0;
            m_creg = '0; m_mreg = 2'b00; m_mode = 2'b00;
            m_prev_wr = 1; m_prev_rd = 1;
        end else begin
            tc = 0;
            old_run = m_run;
            if (m_run && tick) begin
                m_k++;
                if (m_k == m_n) begin
                    tc = 1;
                    if (m_mode[0] && !m_pend) begin
                        m_k = 0; m_n = load_val(m_creg); m_mode = m_mreg;
                    end else begin
                        m_run = 0; m_pend = 0;
                    end
                end
            end
            if (commit) begin
                case (address[1:0])
                    2'd0: case (data[7:6])
                        2'b01: m_run = 0;
                        2'b10: if (old_run) m_pend = 1;
                        2'b11: begin
                            m_k = 0; m_n = load_val(m_creg); m_mode = m_mreg;
                            m_run = 1; m_pend = 0;
                        end
                        default: ;
                    endcase
                    2'd1: m_creg[7:0] = data;
                    2'd2: begin m_creg[13:8] = data[5:0]; m_mreg = data[7:6]; end
                    default: ;
                endcase
            end
            if (tc) m_flag = 1;
            else if (rd_end) m_flag = 0;
            m_prev_wr = WRn;
            m_prev_rd = RDn;
        end
        if (!m_run)         out = 1;
        else if (m_mode[1]) out = (m_k < (m_n + 1) / 2);
        else                out = (m_k != m_n - 1);
        wave_q.push_back({out, m_flag});
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Single writer for tick: fixed value in directed tests, random later.
    initial forever begin
        @(negedge clk);
        tick = rand_tick ? 1'($urandom_range(0, 1)) : tick_fix;
    end

    // Monitor: samples mid-low-phase, well away from the rising edge.
    initial forever begin
        logic [1:0] ew;
        logic [7:0] er;
        bit rd_act;
        @(negedge clk);
        #2;
        if (wave_q.size() > 0) begin
            ew = wave_q.pop_front();
            n_vec++;
            if ({timer_out, irq} !== ew) begin
                n_err++;
                $display("FAIL wave t=%0t out/irq actual=%b%b required=%b", $time, timer_out, irq, ew);
            end
        end
        rd_act = !CSn && IOMn && !RDn && WRn && (address[7:2] == 6'h10);
        if (rd_act) begin
            n_vec++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL read_unexpected t=%0t actual=%h required=none", $time, data);
            end else begin
                er = rd_q.pop_front();
                if (data !== er) begin
                    n_err++;
                    $display("FAIL read a=%h t=%0t actual=%h required=%h", address, $time, data, er);
                end
            end
        end else if (!tb_drive) begin
            n_vec++;
            if (data !== 8'hzz) begin
                n_err++;
                $display("FAIL bus_z t=%0t actual=%h required=zz", $time, data);
            end
        end
    end

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d, input int len, input bit io);
        @(negedge clk);
        address = a; tb_data = d; tb_drive = 1; IOMn = io; CSn = 0; WRn = 0;
        repeat (len) @(negedge clk);
        WRn = 1;
        @(negedge clk);
        CSn = 1; tb_drive = 0; IOMn = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus_wr(a, d, 1, 1'b1);
    endtask

    task automatic rd(input logic [7:0] a, input bit io);
        @(negedge clk);
        address = a; IOMn = io; CSn = 0; RDn = 0;
        if (io && a[7:2] == 6'h10) rd_q.push_back(model_rd(a[1:0]));
        @(negedge clk);
        RDn = 1;
        @(negedge clk);
        CSn = 1; IOMn = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1; address = 8'h00; IOMn = 0; RDn = 1; WRn = 1; CSn = 1;
        tb_data = 8'h00; tb_drive = 0; rand_tick = 0; tick_fix = 0; tick = 0;
        idle(3);
        rst = 0;
        for (int i = 0; i < 4; i++) rd(8'h40 + 8'(i), 1'b1);

        // Single pulse of 5
        tick_fix = 1;
        wr(8'h41, 8'h05); wr(8'h42, 8'h00); wr(8'h40, 8'hC0);
        idle(10);
        rd(8'h40, 1'b1); rd(8'h40, 1'b1);

        // Continuous square of 7, then stop after next TC
        wr(8'h41, 8'h07); wr(8'h42, 8'hC0); wr(8'h40, 8'hC0);
        idle(24);
        rd(8'h40, 1'b1);
        wr(8'h40, 8'h80);
        idle(20);

        // Count 0 behaves as the minimum count
        wr(8'h41, 8'h00); wr(8'h42, 8'h40); wr(8'h40, 8'hC0);
        idle(10);
        wr(8'h40, 8'h40);

        // Long write strobe gives a single start
        wr(8'h41, 8'h05); wr(8'h42, 8'h00);
        bus_wr(8'h40, 8'hC0, 10, 1'b1);
        idle(10);

        // Mid-run count change takes effect at the next reload
        wr(8'h41, 8'h09); wr(8'h42, 8'h40); wr(8'h40, 8'hC0);
        idle(3);
        wr(8'h41, 8'h03);
        idle(25);

        // Reset mid-count
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        idle(3);
        for (int i = 0; i < 4; i++) rd(8'h40 + 8'(i), 1'b1);

        // Memory cycle and wrong base ignored
        bus_wr(8'h41, 8'h33, 1, 1'b0);
        bus_wr(8'h45, 8'h33, 1, 1'b1);
        rd(8'h41, 1'b1);
        rd(8'h41, 1'b0);

        // Randomized traffic
        rand_tick = 1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 6))
                0: wr(8'h41, 8'($urandom_range(0, 12)));
                1: wr(8'h42, {2'($urandom_range(0, 3)), 6'h00});
                2: bus_wr(8'h40, {2'($urandom_range(0, 3)), 6'($urandom)}, $urandom_range(1, 3), 1'b1);
                3: rd(8'h40 + 8'($urandom_range(0, 3)), 1'b1);
                4: idle($urandom_range(1, 8));
                5: bus_wr(8'h40 + 8'($urandom_range(0, 7)), 8'($urandom), 1, 1'($urandom_range(0, 1)));
                default: wr(8'h40, 8'hC0);
            endcase
        end
        idle(5);
        if (rd_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL read_pending actual=%0d required=0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
